// File: rtl/alu32.sv
// alu32: registered 32-bit ALU (add/sub/logic/signed slt) with one-cycle latency.
// Define ALU32_SHIFT_EN to make opcode 010 a logical left shift; otherwise it yields zero.
module alu32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUop,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_XOR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_SLT = 3'b110,
    OP_NOR = 3'b111
  } aluop_t;

  logic        subtract;
  logic [31:0] bopnd;
  logic [32:0] sum;
  logic        addovf;
  logic        lessthan;
  logic [31:0] nxtresult;
  logic        nxtoverflow;
  logic        nxtcarry;

  // SUB and SLT share the adder as A + ~B + 1, so its carry means unsigned A >= B
  always_comb begin
    subtract = (ALUop == OP_SUB) || (ALUop == OP_SLT);
    bopnd    = subtract ? ~B : B;
    sum      = {1'b0, A} + {1'b0, bopnd} + {32'd0, subtract};
    addovf   = (A[31] == bopnd[31]) && (sum[31] != A[31]);
    lessthan = sum[31] ^ addovf;
  end

  always_comb begin
    nxtresult   = 32'd0;
    nxtoverflow = 1'b0;
    nxtcarry    = 1'b0;
    case (ALUop)
      OP_ADD, OP_SUB: begin
        nxtresult   = sum[31:0];
        nxtoverflow = addovf;
        nxtcarry    = sum[32];
      end
      OP_SLL: begin
`ifdef ALU32_SHIFT_EN
        nxtresult = A << B[4:0];
`else
        nxtresult = 32'd0;
`endif
      end
      OP_XOR: nxtresult = A ^ B;
      OP_AND: nxtresult = A & B;
      OP_OR:  nxtresult = A | B;
      OP_SLT: begin
        nxtresult = {31'd0, lessthan};
        nxtcarry  = sum[32];
      end
      OP_NOR: nxtresult = ~(A | B);
    endcase
  end

  // Reset wins over the operation sampled on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Result   <= 32'd0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else begin
      Result   <= nxtresult;
      Zero     <= (nxtresult == 32'd0);
      Overflow <= nxtoverflow;
      CarryOut <= nxtcarry;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed-vector bench for alu32 with hand-computed expected values.
// Opcode 010 expectations follow ALU32_SHIFT_EN as defined for the build.
module tb_alu32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUop;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLL = 3'b010, XORO = 3'b011,
                         ANDO = 3'b100, ORO = 3'b101, SLT = 3'b110, NORO = 3'b111;

  alu32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ALUop    (ALUop),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Drive inputs, let one rising edge sample them, then settle 1 time unit past it
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUop = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic runVector(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expRes,
                           input logic expCarry, input logic expOvf);
    applyStimulus(op, a, b);
    checkOutput({tag, ".res"}, Result, expRes);
    checkOutput({tag, ".zero"}, {31'd0, Zero}, {31'd0, expRes == 32'd0});
    checkOutput({tag, ".carry"}, {31'd0, CarryOut}, {31'd0, expCarry});
    checkOutput({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, expOvf});
  endtask

  initial begin
    rst_n = 1'b0;
    ALUop = ADD;
    A     = 32'hFFFFFFFF;
    B     = 32'h00000001;
    @(posedge clk);
    A = $urandom;
    B = $urandom;
    @(posedge clk);
    #1;
    checkOutput("rst.res", Result, 32'd0);
    checkOutput("rst.zero", {31'd0, Zero}, 32'd1);
    checkOutput("rst.ovf", {31'd0, Overflow}, 32'd0);
    checkOutput("rst.carry", {31'd0, CarryOut}, 32'd0);
    rst_n = 1'b1;

    runVector("first", ADD, 32'd16, 32'd34, 32'd50, 1'b0, 1'b0);
    runVector("add", ADD, 32'd100, 32'd100, 32'd200, 1'b0, 1'b0);
    runVector("sub1", SUB, 32'd100, 32'd47, 32'd53, 1'b1, 1'b0);
    runVector("sub2", SUB, 32'd105, 32'd3, 32'd102, 1'b1, 1'b0);
    runVector("subzero", SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    runVector("addovf", ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
    runVector("addcarry", ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    runVector("subovf", SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1);
    runVector("subborrow", SUB, 32'd3, 32'd10, 32'hFFFFFFF9, 1'b0, 1'b0);

    runVector("xor", XORO, 32'hABDF1234, 32'h01259ECF, 32'hAAFA8CFB, 1'b0, 1'b0);
    runVector("and", ANDO, 32'hABDF1234, 32'h01259ECF, 32'h01051204, 1'b0, 1'b0);
    runVector("or", ORO, 32'hABDF1234, 32'h01259ECF, 32'hABFF9EFF, 1'b0, 1'b0);
    runVector("nor", NORO, 32'hABDF1234, 32'h01259ECF, 32'h54006100, 1'b0, 1'b0);
    runVector("xor1", XORO, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    runVector("and1", ANDO, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0);
    runVector("or1", ORO, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    runVector("nor1", NORO, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0);

    runVector("slt1", SLT, 32'd100, 32'd47, 32'd0, 1'b1, 1'b0);
    runVector("slt2", SLT, 32'd100, 32'd147, 32'd1, 1'b0, 1'b0);
    runVector("slt3", SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 1'b0);
    runVector("slt4", SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0);

`ifdef ALU32_SHIFT_EN
    runVector("sll1", SLL, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0);
    runVector("sll2", SLL, 32'd3, 32'd33, 32'd6, 1'b0, 1'b0);
`else
    runVector("sll1", SLL, 32'd1, 32'd31, 32'd0, 1'b0, 1'b0);
    runVector("sll2", SLL, 32'd3, 32'd33, 32'd0, 1'b0, 1'b0);
`endif

    runVector("prerst", ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    runVector("midrst", ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    runVector("bb1", SUB, 32'd10, 32'd3, 32'd7, 1'b1, 1'b0);
    runVector("bb2", XORO, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0);
    runVector("bb3", ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0);
    runVector("bb4", SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
